// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared constants and types for the RV32I store unit
//
// Purpose: funct3 encodings for SB/SH/SW, FSM state encoding and the
// err_cause codes reported by store_unit.
// Ports: none (package).

package store_pkg;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - combinational byte-lane steering for SB/SH/SW
//
// Purpose: maps the store source value onto the 32-bit memory bus with
// per-byte write strobes, and flags illegal funct3 and misaligned addresses.
// Ports:
//   funct3     in   3   store width selector
//   addr_lo    in   2   low two bits of the byte address
//   rs2_data   in   32  store source value
//   wdata      out  32  lane-replicated write data
//   wstrb      out  4   byte write enables (0 for illegal funct3)
//   misaligned out  1   SH with addr_lo[0]=1, or SW with addr_lo!=0
//   illegal    out  1   funct3 is not SB/SH/SW

module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        illegal
);

  // SH lane choice depends only on addr_lo[1], and SW always uses all four
  // lanes, so the strobes are the same whether or not the address has had
  // its low bits cleared.
  always_comb begin
    wdata      = 32'h0;
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      FUNCT3_SB: begin
        wdata = {4{rs2_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      FUNCT3_SH: begin
        wdata      = {2{rs2_data[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      FUNCT3_SW: begin
        wdata      = rs2_data;
        wstrb      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32I store stage: address add, lane align, mem req/ack
//
// Purpose: accepts one decoded store, computes addr = rs1 + imm, steers data
// onto byte lanes and runs a req/ack write to data memory with a wait timeout.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned SH/SW with cause 10
// instead of clearing the low address bits and issuing).
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid / in_ready       store handshake (in_ready high only in IDLE)
//   funct3, rs1_data,
//   rs2_data, imm             decoded store operands
//   mem_req / mem_ack         memory write handshake
//   mem_addr, mem_wdata,
//   mem_wstrb                 write address/data/strobes, stable while mem_req
//   done                      1-cycle pulse: store completed
//   err, err_cause            1-cycle pulse with cause 01 illegal,
//                             10 misaligned, 11 timeout

module store_unit
  import store_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] addr_sum;
  logic [31:0] addr_issue;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic        lane_misaligned;
  logic        lane_illegal;

  // Wraps mod 2^32; the carry out is intentionally dropped.
  assign addr_sum = rs1_data + imm;

  store_lane_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr_sum[1:0]),
    .rs2_data   (rs2_data),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .misaligned (lane_misaligned),
    .illegal    (lane_illegal)
  );

`ifdef MISALIGN_TRAP_EN
  // Misaligned stores never issue, so the address goes out unmodified.
  assign addr_issue = addr_sum;
`else
  // Misaligned stores issue to the naturally aligned address below them.
  always_comb begin
    addr_issue = addr_sum;
    if (lane_misaligned) begin
      if (funct3 == FUNCT3_SW) addr_issue = {addr_sum[31:2], 2'b00};
      else                     addr_issue = {addr_sum[31:1], 1'b0};
    end
  end
`endif

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= ERR_NONE;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= ERR_NONE;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mem_addr  <= addr_issue;
            mem_wdata <= lane_wdata;
            mem_wstrb <= lane_wstrb;
            if (lane_illegal) begin
              err       <= 1'b1;
              err_cause <= ERR_ILLEGAL;
            end
`ifdef MISALIGN_TRAP_EN
            else if (lane_misaligned) begin
              err       <= 1'b1;
              err_cause <= ERR_MISALIGN;
            end
`endif
            else begin
              state    <= ST_REQ;
              mem_req  <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        ST_REQ: begin
          // An ack on the expiry cycle still completes the store.
          if (mem_ack) begin
            done     <= 1'b1;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err       <= 1'b1;
            err_cause <= ERR_TIMEOUT;
            mem_req   <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit

module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;

  int total  = 0;
  int passed = 0;

  store_unit #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err),
    .err_cause (err_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] r1,
                         input logic [31:0] i, input logic [31:0] r2);
    in_valid = 1'b1;
    funct3   = f3;
    rs1_data = r1;
    imm      = i;
    rs2_data = r2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; funct3 = 3'b000;
    rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0; mem_ack = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_done_err", {30'h0, done, err}, 32'h0);
    check("rst_err_cause", 32'(err_cause), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // mem_ack outside REQ has no effect
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("stray_ack_done", 32'(done), 32'h0);
    check("stray_ack_req", 32'(mem_req), 32'h0);

    // SW, ack three cycles into REQ
    present(3'b010, 32'h0000_1000, 32'h0000_0008, 32'hDEAD_BEEF);
    step();
    in_valid = 1'b0;
    check("sw_req", 32'(mem_req), 32'h1);
    check("sw_in_ready", 32'(in_ready), 32'h0);
    check("sw_addr", mem_addr, 32'h0000_1008);
    check("sw_wstrb", 32'(mem_wstrb), 32'hF);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); step();
    check("sw_addr_stable", mem_addr, 32'h0000_1008);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sw_done", 32'(done), 32'h1);
    check("sw_req_low", 32'(mem_req), 32'h0);
    check("sw_in_ready_back", 32'(in_ready), 32'h1);
    step();
    check("sw_done_pulse", 32'(done), 32'h0);

    // SB with negative offset, acked in the first REQ cycle
    present(3'b000, 32'h0000_2003, 32'hFFFF_FFFF, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    check("sb_addr", mem_addr, 32'h0000_2002);
    check("sb_wstrb", 32'(mem_wstrb), 32'h4);
    check("sb_wdata", mem_wdata, 32'h7878_7878);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sb_done", 32'(done), 32'h1);

    // Back-to-back: SH to 0x1001 presented in the done cycle
    present(3'b001, 32'h0000_1000, 32'h0000_0001, 32'h1234_5678);
    step();
    in_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("sh_mis_err", 32'(err), 32'h1);
    check("sh_mis_cause", 32'(err_cause), 32'h2);
    check("sh_mis_no_req", 32'(mem_req), 32'h0);
    step();
`else
    check("sh_mis_req", 32'(mem_req), 32'h1);
    check("sh_mis_addr", mem_addr, 32'h0000_1000);
    check("sh_mis_wstrb", 32'(mem_wstrb), 32'h3);
    check("sh_mis_wdata", mem_wdata, 32'h5678_5678);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sh_mis_done", 32'(done), 32'h1);
    check("sh_mis_no_err", 32'(err), 32'h0);
    step();
`endif

    // Address wrap: 0xFFFFFFFF + 1 = 0
    present(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_00A5);
    step();
    in_valid = 1'b0;
    check("wrap_addr", mem_addr, 32'h0000_0000);
    check("wrap_wstrb", 32'(mem_wstrb), 32'h1);
    check("wrap_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    // Illegal funct3
    present(3'b011, 32'h0000_3000, 32'h0, 32'h1111_2222);
    step();
    in_valid = 1'b0;
    check("ill_err", 32'(err), 32'h1);
    check("ill_cause", 32'(err_cause), 32'h1);
    check("ill_no_req", 32'(mem_req), 32'h0);
    check("ill_in_ready", 32'(in_ready), 32'h1);
    step();
    check("ill_err_pulse", 32'(err), 32'h0);
    check("ill_still_no_req", 32'(mem_req), 32'h0);

    // Timeout: no ack for all 16 wait cycles
    present(3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req_%0d", i), {30'h0, mem_req, err}, 32'h2);
      step();
    end
    check("to_err", 32'(err), 32'h1);
    check("to_cause", 32'(err_cause), 32'h3);
    check("to_req_low", 32'(mem_req), 32'h0);
    check("to_no_done", 32'(done), 32'h0);
    step();

    // Ack on the last wait cycle wins over timeout
    present(3'b010, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("last_req_high", 32'(mem_req), 32'h1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("last_done", 32'(done), 32'h1);
    check("last_no_err", 32'(err), 32'h0);
    step();

    // Reset asserted mid-REQ
    present(3'b010, 32'h0000_0100, 32'h0, 32'h5555_AAAA);
    step();
    in_valid = 1'b0;
    check("rreq_req", 32'(mem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rreq_req_drop", 32'(mem_req), 32'h0);
    check("rreq_in_ready", 32'(in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();
    check("rreq_no_pulse", {30'h0, done, err}, 32'h0);
    check("rreq_idle", {30'h0, in_ready, mem_req}, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
